// File: rtl/ram_dp_pkg.sv
// Shared types and constants for the dual-port RAM.
//   state_e         : clear-sequencer states
//   RDW_READ_FIRST  : a read that collides with a write returns the old word
//   RDW_WRITE_FIRST : a read that collides with a write returns the new word
package ram_dp_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_dp_rdport.sv
// Read side of one RAM port: read-during-write selection, output pipeline and valid.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rd           : read accepted this cycle (already gated by busy)
//   i_mem_data     : current array contents at the read address
//   i_fwd_hit      : a write to the read address is happening this cycle
//   i_fwd_data     : data of that write
//   o_dout, o_vld  : registered read data and its valid flag
module ram_dp_rdport
  import ram_dp_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_fwd_hit,
  input  logic [DATA_W-1:0] i_fwd_data,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_vld
);

  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_dout1;
  logic              r_vld1;

  assign w_rd_data = ((RDW_MODE == RDW_WRITE_FIRST) && i_fwd_hit) ? i_fwd_data : i_mem_data;

  // dout holds its last value when no read is performed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout1 <= '0;
      r_vld1  <= 1'b0;
    end else begin
      r_vld1 <= i_rd;
      if (i_rd) r_dout1 <= w_rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_dout2;
    logic              r_vld2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_dout2 <= '0;
        r_vld2  <= 1'b0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_dout2 <= r_dout1;
      end
    end

    assign o_dout = r_dout2;
    assign o_vld  = r_vld2;
  end else begin : g_noreg
    assign o_dout = r_dout1;
    assign o_vld  = r_vld1;
  end

endmodule

// File: rtl/ram_dp_sync.sv
// Synchronous true dual-port RAM with post-reset zero-fill and collision flag.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_a_wr/i_b_wr             : write strobes
//   i_a_rd/i_b_rd             : read strobes
//   i_a_add/i_b_add           : addresses
//   i_a_din/i_b_din           : write data
//   o_a_dout/o_b_dout         : registered read data
//   o_a_vld/o_b_vld           : read data valid
//   o_coll                    : one-cycle pulse after a same-address write/write
//   o_busy                    : zero-fill in progress, all requests ignored
module ram_dp_sync
  import ram_dp_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned CLR_EN   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_wr,
  input  logic              i_b_wr,
  input  logic              i_a_rd,
  input  logic              i_b_rd,
  input  logic [ADDR_W-1:0] i_a_add,
  input  logic [ADDR_W-1:0] i_b_add,
  input  logic [DATA_W-1:0] i_a_din,
  input  logic [DATA_W-1:0] i_b_din,
  output logic [DATA_W-1:0] o_a_dout,
  output logic [DATA_W-1:0] o_b_dout,
  output logic              o_a_vld,
  output logic              o_b_vld,
  output logic              o_coll,
  output logic              o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic              w_clr_we;
  logic              w_ready;
  logic              w_same_add;
  logic              w_a_we, w_b_we;
  logic              w_a_hit, w_b_hit;
  logic [DATA_W-1:0] w_a_fwd, w_b_fwd;
  logic              r_coll;

  // Clear sequencer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= (CLR_EN != 0) ? CLEAR : READY;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_nxt = READY;
      end
      READY: ;
      default: w_state_nxt = READY;
    endcase
  end

  assign w_ready    = (r_state == READY);
  assign w_same_add = (i_a_add == i_b_add);

  // Port A wins a same-address write/write
  assign w_a_we = w_ready & i_a_wr;
  assign w_b_we = w_ready & i_b_wr & ~(i_a_wr & w_same_add);

  // Contents are deliberately not reset; the zero-fill takes care of that
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_a_we) r_mem[i_a_add] <= i_a_din;
      if (w_b_we) r_mem[i_b_add] <= i_b_din;
    end
  end

  // Forwarding candidates, port A data taking priority on a collision
  assign w_a_hit = i_a_wr | (i_b_wr & w_same_add);
  assign w_a_fwd = i_a_wr ? i_a_din : i_b_din;
  assign w_b_hit = i_b_wr | (i_a_wr & w_same_add);
  assign w_b_fwd = (i_a_wr & w_same_add) ? i_a_din : i_b_din;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_coll <= 1'b0;
    else          r_coll <= w_ready & i_a_wr & i_b_wr & w_same_add;
  end

  ram_dp_rdport #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG),
    .RDW_MODE(RDW_MODE)
  ) u_rdport_a (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd      (w_ready & i_a_rd),
    .i_mem_data(r_mem[i_a_add]),
    .i_fwd_hit (w_a_hit),
    .i_fwd_data(w_a_fwd),
    .o_dout    (o_a_dout),
    .o_vld     (o_a_vld)
  );

  ram_dp_rdport #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG),
    .RDW_MODE(RDW_MODE)
  ) u_rdport_b (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd      (w_ready & i_b_rd),
    .i_mem_data(r_mem[i_b_add]),
    .i_fwd_hit (w_b_hit),
    .i_fwd_data(w_b_fwd),
    .o_dout    (o_b_dout),
    .o_vld     (o_b_vld)
  );

  assign o_coll = r_coll;
  assign o_busy = ~w_ready;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed bench for ram_dp_sync. Two instances share the inputs:
//   dut0 : OUT_REG=0, read-first
//   dut1 : OUT_REG=1, write-first
module tb_ram_dp_sync;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_wr, b_wr, a_rd, b_rd;
  logic [AW-1:0] a_add, b_add;
  logic [DW-1:0] a_din, b_din;

  logic [DW-1:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic          a_vld0, b_vld0, a_vld1, b_vld1;
  logic          coll0, coll1, busy0, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_dp_sync #(
    .DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0), .CLR_EN(1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_wr(a_wr), .i_b_wr(b_wr), .i_a_rd(a_rd), .i_b_rd(b_rd),
    .i_a_add(a_add), .i_b_add(b_add), .i_a_din(a_din), .i_b_din(b_din),
    .o_a_dout(a_dout0), .o_b_dout(b_dout0), .o_a_vld(a_vld0), .o_b_vld(b_vld0),
    .o_coll(coll0), .o_busy(busy0)
  );

  ram_dp_sync #(
    .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(1), .CLR_EN(1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_wr(a_wr), .i_b_wr(b_wr), .i_a_rd(a_rd), .i_b_rd(b_rd),
    .i_a_add(a_add), .i_b_add(b_add), .i_a_din(a_din), .i_b_din(b_din),
    .o_a_dout(a_dout1), .o_b_dout(b_dout1), .o_a_vld(a_vld1), .o_b_vld(b_vld1),
    .o_coll(coll1), .o_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr = 1'b0; b_wr = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
    a_add = '0; b_add = '0; a_din = '0; b_din = '0;
  endtask

  // All outputs of both instances at their reset value
  task automatic chk_flush(input string tag);
    chk({tag, "_a_dout0"}, 32'(a_dout0), 'h0);
    chk({tag, "_b_dout0"}, 32'(b_dout0), 'h0);
    chk({tag, "_a_dout1"}, 32'(a_dout1), 'h0);
    chk({tag, "_b_dout1"}, 32'(b_dout1), 'h0);
    chk({tag, "_vld"}, 32'({a_vld0, b_vld0, a_vld1, b_vld1}), 'h0);
    chk({tag, "_coll"}, 32'({coll0, coll1}), 'h0);
    chk({tag, "_busy"}, 32'({busy0, busy1}), 'h3);
  endtask

  // Counts busy cycles until both instances are ready; no vld/coll may appear meanwhile
  task automatic wait_clear(input string tag);
    int   n0;
    int   n1;
    int   g;
    logic seen;
    n0 = 0; n1 = 0; g = 0; seen = 1'b0;
    while ((busy0 || busy1) && g < 40) begin
      if (busy0) n0++;
      if (busy1) n1++;
      tick();
      seen = seen | a_vld0 | b_vld0 | a_vld1 | b_vld1 | coll0 | coll1;
      g++;
    end
    idle();
    chk({tag, "_busy_cycles0"}, 32'(n0), 'd16);
    chk({tag, "_busy_cycles1"}, 32'(n1), 'd16);
    chk({tag, "_quiet_while_busy"}, 32'(seen), 'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk_flush("reset");

    // Release with requests pending: all of them must be ignored during the fill
    rst_n = 1'b1;
    a_wr = 1'b1; a_add = 4'd2; a_din = 8'hEE;
    b_wr = 1'b1; b_add = 4'd2; b_din = 8'hDD;
    a_rd = 1'b1; b_rd = 1'b1;
    wait_clear("clear1");

    // Pipelined readback of every address on both ports
    for (int i = 0; i <= 17; i++) begin
      if (i < 16) begin
        a_rd = 1'b1; a_add = 4'(i);
        b_rd = 1'b1; b_add = 4'(15 - i);
      end else begin
        idle();
      end
      tick();
      if (i < 16) begin
        chk("zero_a_dout0", 32'(a_dout0), 'h0);
        chk("zero_b_dout0", 32'(b_dout0), 'h0);
        chk("zero_vld0", 32'({a_vld0, b_vld0}), 'h3);
      end
      if (i == 0) chk("zero_lat2_vld1", 32'({a_vld1, b_vld1}), 'h0);
      if (i >= 1 && i <= 16) begin
        chk("zero_dout1", 32'({a_dout1, b_dout1}), 'h0);
        chk("zero_vld1", 32'({a_vld1, b_vld1}), 'h3);
      end
      if (i == 16) chk("zero_end_vld0", 32'({a_vld0, b_vld0}), 'h0);
    end

    // A writes 0xA5 @3, B reads @3 next cycle
    a_wr = 1'b1; a_add = 4'd3; a_din = 8'hA5;
    tick(); idle();
    b_rd = 1'b1; b_add = 4'd3;
    tick(); idle();
    chk("wr_rd_b_dout0", 32'(b_dout0), 'hA5);
    chk("wr_rd_b_vld0", 32'(b_vld0), 'h1);
    chk("wr_rd_b_vld1_early", 32'(b_vld1), 'h0);
    tick();
    chk("wr_rd_b_vld0_drop", 32'(b_vld0), 'h0);
    chk("wr_rd_b_dout0_hold", 32'(b_dout0), 'hA5);
    chk("wr_rd_b_dout1", 32'(b_dout1), 'hA5);
    chk("wr_rd_b_vld1", 32'(b_vld1), 'h1);
    tick();
    chk("wr_rd_b_vld1_drop", 32'(b_vld1), 'h0);
    chk("wr_rd_b_dout1_hold", 32'(b_dout1), 'hA5);

    // Cross-port read-during-write @7: old 0x11 vs new 0x22
    a_wr = 1'b1; a_add = 4'd7; a_din = 8'h11;
    tick(); idle();
    a_wr = 1'b1; a_add = 4'd7; a_din = 8'h22;
    b_rd = 1'b1; b_add = 4'd7;
    tick(); idle();
    chk("xrdw_b_dout0", 32'(b_dout0), 'h11);
    chk("xrdw_b_vld0", 32'(b_vld0), 'h1);
    chk("xrdw_no_coll0", 32'(coll0), 'h0);
    tick();
    chk("xrdw_b_dout1", 32'(b_dout1), 'h22);
    chk("xrdw_b_vld1", 32'(b_vld1), 'h1);
    a_rd = 1'b1; a_add = 4'd7; b_rd = 1'b1; b_add = 4'd7;
    tick(); idle();
    chk("xrdw_after_dout0", 32'({a_dout0, b_dout0}), 'h2222);
    tick();
    chk("xrdw_after_dout1", 32'({a_dout1, b_dout1}), 'h2222);

    // Same-port read-during-write @8 (previously 0)
    a_wr = 1'b1; a_rd = 1'b1; a_add = 4'd8; a_din = 8'h55;
    tick(); idle();
    chk("srdw_a_dout0", 32'(a_dout0), 'h00);
    chk("srdw_a_vld0", 32'(a_vld0), 'h1);
    tick();
    chk("srdw_a_dout1", 32'(a_dout1), 'h55);
    chk("srdw_a_vld1", 32'(a_vld1), 'h1);

    // Write/write collision @5 with reads on both ports
    a_wr = 1'b1; a_add = 4'd5; a_din = 8'h33; a_rd = 1'b1;
    b_wr = 1'b1; b_add = 4'd5; b_din = 8'h44; b_rd = 1'b1;
    tick(); idle();
    chk("coll_pulse", 32'({coll0, coll1}), 'h3);
    chk("coll_rd_dout0", 32'({a_dout0, b_dout0}), 'h0000);
    tick();
    chk("coll_clear", 32'({coll0, coll1}), 'h0);
    chk("coll_rd_dout1", 32'({a_dout1, b_dout1}), 'h3333);
    b_rd = 1'b1; b_add = 4'd5;
    tick(); idle();
    chk("coll_after_b_dout0", 32'(b_dout0), 'h33);
    tick();
    chk("coll_after_b_dout1", 32'(b_dout1), 'h33);

    // Writes to different addresses in the same cycle
    a_wr = 1'b1; a_add = 4'd9;  a_din = 8'h66;
    b_wr = 1'b1; b_add = 4'd10; b_din = 8'h77;
    tick(); idle();
    chk("diff_no_coll", 32'({coll0, coll1}), 'h0);
    a_rd = 1'b1; a_add = 4'd9; b_rd = 1'b1; b_add = 4'd10;
    tick(); idle();
    chk("diff_dout0", 32'({a_dout0, b_dout0}), 'h6677);
    tick();
    chk("diff_dout1", 32'({a_dout1, b_dout1}), 'h6677);

    // Reset during a read stream
    a_rd = 1'b1; a_add = 4'd7; b_rd = 1'b1; b_add = 4'd3;
    tick();
    tick();
    chk("stream_dout1", 32'({a_dout1, b_dout1}), 'h22A5);
    rst_n = 1'b0;
    #1;
    chk_flush("rst_stream");
    #3;
    rst_n = 1'b1;

    // Reset again at clear count 9, stream strobes still asserted
    for (int i = 0; i < 9; i++) tick();
    chk("cnt9_busy", 32'({busy0, busy1}), 'h3);
    rst_n = 1'b0;
    #1;
    chk_flush("rst_cnt9");
    #3;
    rst_n = 1'b1;
    a_rd = 1'b1; a_add = 4'd7; b_rd = 1'b1; b_add = 4'd3;
    wait_clear("clear2");

    // First cycle after busy falls is accepted; contents are zero again
    a_rd = 1'b1; a_add = 4'd3; b_rd = 1'b1; b_add = 4'd7;
    tick(); idle();
    chk("post_dout0", 32'({a_dout0, b_dout0}), 'h0000);
    chk("post_vld0", 32'({a_vld0, b_vld0}), 'h3);
    tick();
    chk("post_dout1", 32'({a_dout1, b_dout1}), 'h0000);
    chk("post_vld1", 32'({a_vld1, b_vld1}), 'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
